// File: rtl/balun_lpf_pkg.sv
// balun_lpf_pkg: FSM encoding and fixed-point rounding/saturation helpers for balun_lpf_tdm
package balun_lpf_pkg;
  localparam int MAX_STAGES = 8;
  typedef enum logic [1:0] {S_IDLE, S_DIFF, S_STAGE, S_HOLD} fsm_state_e;
  function automatic logic signed [63:0] round_half_up(input logic signed [63:0] v, input int sh);
    return (v + (64'sd1 <<< (sh - 1))) >>> sh;
  endfunction
  function automatic logic signed [63:0] sat_to_w(input logic signed [63:0] v, input int w);
    logic signed [63:0] lim;
    lim = 64'sd1 <<< (w - 1);
    return (v >= lim) ? lim - 64'sd1 : (v < -lim) ? -lim : v;
  endfunction
endpackage

// File: rtl/balun_lpf_tdm_section.sv
// lpf_iir_section: one first-order low-pass update s + ((x - s) >>> SHIFT)
module lpf_iir_section #(
  parameter int W     = 18,
  parameter int SHIFT = 2
) (
  input  logic signed [W-1:0] i_x,
  input  logic signed [W-1:0] i_s,
  output logic signed [W-1:0] o_s_next
);
  logic signed [W:0] w_diff;
  assign w_diff   = (W+1)'(i_x) - (W+1)'(i_s);
  assign o_s_next = i_s + W'(w_diff >>> SHIFT);
endmodule

// File: rtl/balun_lpf_tdm.sv
// balun_lpf_tdm: TDM balun + cascaded IIR low-pass per channel; LPF_DC_PROBE_EN adds a per-channel DC mean probe
module balun_lpf_tdm
  import balun_lpf_pkg::*;
#(
  parameter int CHANNELS   = 2,
  parameter int DATA_W     = 16,
  parameter int STAGES     = 3,
  parameter int SHIFT      = 2,
  parameter int PROBE_LOG2 = 4,
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CW-1:0]            in_chan,
  input  logic signed [DATA_W-1:0] in_p,
  input  logic signed [DATA_W-1:0] in_n,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CW-1:0]            out_chan,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     chan_err,
  input  logic                     clr_chan,
  input  logic [CW-1:0]            clr_idx
`ifdef LPF_DC_PROBE_EN
  ,
  input  logic [CW-1:0]            probe_idx,
  output logic signed [DATA_W-1:0] probe_mean,
  output logic                     probe_vld
`endif
);
  localparam int KW = STAGES > 1 ? $clog2(STAGES) : 1;
  localparam int SW = DATA_W + SHIFT;
  if (STAGES < 1 || STAGES > MAX_STAGES || SHIFT < 1 || SHIFT > 8 || PROBE_LOG2 < 1) begin : g_bad_cfg
    $error("balun_lpf_tdm: parameter out of range");
  end
  fsm_state_e r_st, w_nxt;
  logic [KW-1:0] r_k;
  logic [CW-1:0] r_ch, r_oc;
  logic signed [DATA_W-1:0] r_p, r_n, r_out;
  logic signed [SW-1:0] r_x, w_s_cur, w_s_nxt;
  logic signed [SW-1:0] r_s [CHANNELS][STAGES];
  logic signed [DATA_W:0] w_dw;
  logic r_rdy, r_err, w_cap, w_ok, w_last, w_hs;
  logic [CHANNELS-1:0] r_clr, w_clr_hit, w_clr;
  assign w_cap   = in_valid && r_rdy;
  assign w_ok    = 32'(in_chan) < CHANNELS;
  assign w_last  = r_k == KW'(STAGES - 1);
  assign w_hs    = r_st == S_HOLD && out_ready;
  assign w_dw    = (DATA_W+1)'(r_p) - (DATA_W+1)'(r_n);
  assign w_s_cur = r_s[r_ch][r_k];
  assign w_clr   = r_clr | w_clr_hit;
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) w_clr_hit[c] = clr_chan && 32'(clr_idx) == c;
  end
  lpf_iir_section #(.W(SW), .SHIFT(SHIFT)) u_sec (
    .i_x(r_x), .i_s(w_s_cur), .o_s_next(w_s_nxt)
  );
  always_comb begin
    w_nxt = r_st;
    case (r_st)
      S_IDLE:  w_nxt = (w_cap && w_ok) ? S_DIFF : S_IDLE;
      S_DIFF:  w_nxt = S_STAGE;
      S_STAGE: w_nxt = w_last ? S_HOLD : S_STAGE;
      S_HOLD:  w_nxt = out_ready ? S_IDLE : S_HOLD;
      default: w_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) r_st <= rst ? S_IDLE : w_nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdy <= 1'b0;
      r_err <= 1'b0;
      r_k   <= '0;
      r_ch  <= '0;
      r_oc  <= '0;
      r_p   <= '0;
      r_n   <= '0;
      r_x   <= '0;
      r_out <= '0;
      r_clr <= '0;
      for (int c = 0; c < CHANNELS; c++)
        for (int k = 0; k < STAGES; k++) r_s[c][k] <= '0;
    end else begin
      r_rdy <= w_nxt == S_IDLE;
      r_err <= w_cap && !w_ok;
      r_clr <= (r_st == S_IDLE) ? '0 : w_clr;
      if (w_cap && w_ok) begin
        r_ch <= in_chan;
        r_p  <= in_p;
        r_n  <= in_n;
      end
      if (r_st == S_DIFF) begin
        r_x <= SW'(w_dw >>> 1) <<< SHIFT;
        r_k <= '0;
      end
      if (r_st == S_STAGE) begin
        r_s[r_ch][r_k] <= w_s_nxt;
        r_x <= w_s_nxt;
        r_k <= r_k + KW'(1);
        if (w_last) begin
          r_out <= DATA_W'(sat_to_w(round_half_up(64'(w_s_nxt), SHIFT), DATA_W));
          r_oc  <= r_ch;
        end
      end
      // Clears only land while idle, so an in-flight sample never sees its state vanish mid-cascade
      if (r_st == S_IDLE)
        for (int c = 0; c < CHANNELS; c++)
          if (w_clr[c])
            for (int k = 0; k < STAGES; k++) r_s[c][k] <= '0;
    end
  end
  assign in_ready  = r_rdy;
  assign out_valid = r_st == S_HOLD;
  assign out_data  = r_out;
  assign out_chan  = r_oc;
  assign chan_err  = r_err;
`ifdef LPF_DC_PROBE_EN
  localparam int AW = DATA_W + PROBE_LOG2;
  logic signed [AW-1:0] r_acc [CHANNELS];
  logic [PROBE_LOG2-1:0] r_cnt [CHANNELS];
  logic signed [DATA_W-1:0] r_mean [CHANNELS];
  logic [CHANNELS-1:0] r_pv;
  logic signed [AW-1:0] w_sum;
  logic w_pok;
  assign w_sum      = r_acc[r_oc] + AW'(r_out);
  assign w_pok      = 32'(probe_idx) < CHANNELS;
  assign probe_mean = w_pok ? r_mean[probe_idx] : '0;
  assign probe_vld  = w_pok && r_pv[probe_idx];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pv <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_acc[c]  <= '0;
        r_cnt[c]  <= '0;
        r_mean[c] <= '0;
      end
    end else if (w_hs) begin
      r_acc[r_oc] <= (&r_cnt[r_oc]) ? '0 : w_sum;
      r_cnt[r_oc] <= r_cnt[r_oc] + PROBE_LOG2'(1);
      if (&r_cnt[r_oc]) begin
        r_mean[r_oc] <= w_sum[AW-1:PROBE_LOG2];
        r_pv[r_oc]   <= 1'b1;
      end
    end else if (r_st == S_IDLE) begin
      for (int c = 0; c < CHANNELS; c++)
        if (w_clr[c]) begin
          r_acc[c]  <= '0;
          r_cnt[c]  <= '0;
          r_mean[c] <= '0;
          r_pv[c]   <= 1'b0;
        end
    end
  end
`endif
endmodule
